// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between the instruction-fetch and
// load/store requesters, running each access over a fixed LATENCY-cycle window.
module mem_port_arbiter #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {GNT_IF, GNT_D} gnt_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   gnt_t              last_grant, id_lat, grant_sel;
   logic              grant_vld;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] wdata_lat;
   logic              we_lat;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      grant_vld = if_req | d_req;
      grant_sel = GNT_IF;
      if (if_req && d_req)
         grant_sel = (last_grant == GNT_D) ? GNT_IF : GNT_D;
      else if (d_req)
         grant_sel = GNT_D;
   end

   always_comb begin
      state_nxt = state;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if_done   = 1'b0;
      d_done    = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            busy      = 1'b1;
            mem_addr  = addr_lat;
            mem_wdata = wdata_lat;
            mem_read  = ~we_lat;
            mem_write = we_lat;
            if (cnt == '0)
               state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            if_done   = (id_lat == GNT_IF);
            d_done    = (id_lat == GNT_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= GNT_D;
         id_lat     <= GNT_IF;
         addr_lat   <= '0;
         wdata_lat  <= '0;
         we_lat     <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  id_lat     <= grant_sel;
                  last_grant <= grant_sel;
                  cnt        <= CNT_INIT;
                  if (grant_sel == GNT_D) begin
                     addr_lat  <= d_addr;
                     wdata_lat <= d_wdata;
                     we_lat    <= d_we;
                  end else begin
                     addr_lat  <= if_addr;
                     wdata_lat <= '0;
                     we_lat    <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!we_lat) begin
                  if (id_lat == GNT_IF)
                     if_rdata <= mem_rdata;
                  else
                     d_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
